// File: rtl/axi_lite_ctrl_master.sv
// AXI-Lite initiator: converts a valid/ready command port into single, non-overlapping
// AXI-Lite read/write transactions and returns data, error flag and latency per command.

package axi_lite_ctrl_master_pkg;
  localparam int unsigned AxiAddrWidth = 32;
  localparam int unsigned AxiDataWidth = 32;
  localparam int unsigned AxiStrbWidth = AxiDataWidth / 8;

  typedef struct packed {
    logic [AxiAddrWidth-1:0] addr;
    logic [2:0]              prot;
  } axi_lite_ax_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [AxiStrbWidth-1:0] strb;
  } axi_lite_w_t;

  typedef struct packed {
    logic [1:0] resp;
  } axi_lite_b_t;

  typedef struct packed {
    logic [AxiDataWidth-1:0] data;
    logic [1:0]              resp;
  } axi_lite_r_t;

  typedef struct packed {
    axi_lite_ax_t aw;
    logic         aw_valid;
    axi_lite_w_t  w;
    logic         w_valid;
    logic         b_ready;
    axi_lite_ax_t ar;
    logic         ar_valid;
    logic         r_ready;
  } axi_lite_req_t;

  typedef struct packed {
    logic        aw_ready;
    logic        w_ready;
    axi_lite_b_t b;
    logic        b_valid;
    logic        ar_ready;
    axi_lite_r_t r;
    logic        r_valid;
  } axi_lite_resp_t;
endpackage

module axi_lite_ctrl_master #(
  parameter int unsigned DataWidth = 32,
  parameter int unsigned AddrWidth = 32,
  parameter int unsigned CntWidth  = 16,
  parameter type axi_lite_req_t  = axi_lite_ctrl_master_pkg::axi_lite_req_t,
  parameter type axi_lite_resp_t = axi_lite_ctrl_master_pkg::axi_lite_resp_t
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   cmd_valid_i,
  output logic                   cmd_ready_o,
  input  logic                   cmd_we_i,
  input  logic [AddrWidth-1:0]   cmd_addr_i,
  input  logic [DataWidth-1:0]   cmd_wdata_i,
  input  logic [DataWidth/8-1:0] cmd_strb_i,
  output logic                   rsp_valid_o,
  input  logic                   rsp_ready_i,
  output logic [DataWidth-1:0]   rsp_rdata_o,
  output logic                   rsp_err_o,
  output logic [CntWidth-1:0]    rsp_cycles_o,
  output axi_lite_req_t          axi_lite_master_req_o,
  input  axi_lite_resp_t         axi_lite_master_resp_i
);

  typedef enum logic [2:0] {IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP} state_t;

  state_t              state;
  logic [CntWidth-1:0] cnt;
  axi_lite_req_t       req;

  // A channel counts as done once its valid has dropped or is handshaking this cycle
  logic aw_done_c;
  logic w_done_c;
  assign aw_done_c = !req.aw_valid || axi_lite_master_resp_i.aw_ready;
  assign w_done_c  = !req.w_valid  || axi_lite_master_resp_i.w_ready;

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state       <= IDLE;
      req         <= '0;
      cnt         <= '0;
      cmd_ready_o <= 1'b1;
      rsp_valid_o <= 1'b0;
      rsp_rdata_o <= '0;
      rsp_err_o   <= 1'b0;
    end else begin
      // Latency counts every bus-side cycle, saturating at all-ones
      if ((state inside {WRITE, WAIT_B, READ, WAIT_R}) && (cnt != '1)) begin
        cnt <= cnt + CntWidth'(1);
      end

      case (state)
        IDLE: begin
          if (cmd_valid_i && cmd_ready_o) begin
            cmd_ready_o  <= 1'b0;
            cnt          <= '0;
            req.aw.addr  <= cmd_addr_i;
            req.aw.prot  <= 3'b000;
            req.ar.addr  <= cmd_addr_i;
            req.ar.prot  <= 3'b000;
            req.w.data   <= cmd_wdata_i;
            req.w.strb   <= cmd_strb_i;
            if (cmd_we_i) begin
              state        <= WRITE;
              req.aw_valid <= 1'b1;
              req.w_valid  <= 1'b1;
            end else begin
              state        <= READ;
              req.ar_valid <= 1'b1;
            end
          end
        end

        WRITE: begin
          if (axi_lite_master_resp_i.aw_ready) req.aw_valid <= 1'b0;
          if (axi_lite_master_resp_i.w_ready)  req.w_valid  <= 1'b0;
          if (aw_done_c && w_done_c) begin
            state       <= WAIT_B;
            req.b_ready <= 1'b1;
          end
        end

        WAIT_B: begin
          if (axi_lite_master_resp_i.b_valid) begin
            state       <= RESP;
            req.b_ready <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= '0;
            rsp_err_o   <= (axi_lite_master_resp_i.b.resp != 2'b00);
          end
        end

        READ: begin
          if (axi_lite_master_resp_i.ar_ready) begin
            state        <= WAIT_R;
            req.ar_valid <= 1'b0;
            req.r_ready  <= 1'b1;
          end
        end

        WAIT_R: begin
          if (axi_lite_master_resp_i.r_valid) begin
            state       <= RESP;
            req.r_ready <= 1'b0;
            rsp_valid_o <= 1'b1;
            rsp_rdata_o <= axi_lite_master_resp_i.r.data;
            rsp_err_o   <= (axi_lite_master_resp_i.r.resp != 2'b00);
          end
        end

        RESP: begin
          if (rsp_ready_i) begin
            state       <= IDLE;
            rsp_valid_o <= 1'b0;
            cmd_ready_o <= 1'b1;
          end
        end

        default: state <= IDLE;
      endcase
    end
  end

  assign rsp_cycles_o          = cnt;
  assign axi_lite_master_req_o = req;

endmodule

// File: doc/axi_lite_ctrl_master.md
Name: axi_lite_ctrl_master

Overview:
AXI-Lite initiator that turns a simple valid/ready command port into single, non-overlapping AXI-Lite read or write transactions. It lets a host-side agent (bench driver, debug bridge, boot sequencer) program and poll the SoC control-register slave. It returns read data, an error flag and a transaction-latency count per command. Exactly one transaction is outstanding at any time.

Parameters:
DataWidth, 32, AXI-Lite data width in bits; multiple of 8.
AddrWidth, 32, AXI-Lite address width in bits.
CntWidth, 16, width of the latency counter; saturates at all-ones.
axi_lite_req_t, logic, AXI-Lite request struct (aw, aw_valid, w, w_valid, b_ready, ar, ar_valid, r_ready).
axi_lite_resp_t, logic, AXI-Lite response struct (aw_ready, w_ready, b, b_valid, ar_ready, r, r_valid).

Ports:
clk_i  in  1  clock
rst_i  in  1  reset, asynchronous, active-high
cmd_valid_i  in  1  command valid
cmd_ready_o  out  1  command accepted when valid and ready are both high
cmd_we_i  in  1  1 = write, 0 = read
cmd_addr_i  in  AddrWidth  byte address
cmd_wdata_i  in  DataWidth  write data
cmd_strb_i  in  DataWidth/8  write byte strobes
rsp_valid_o  out  1  response valid
rsp_ready_i  in  1  response accepted
rsp_rdata_o  out  DataWidth  read data; 0 for writes
rsp_err_o  out  1  B/R resp != OKAY (SLVERR or DECERR)
rsp_cycles_o  out  CntWidth  cycles from command acceptance to the B/R handshake
axi_lite_master_req_o  out  axi_lite_req_t  AXI-Lite request channels
axi_lite_master_resp_i  in  axi_lite_resp_t  AXI-Lite response channels

Behaviour:
- Reset (rst_i high, asynchronous):
  - State goes to IDLE.
  - All AXI valid and ready outputs are 0.
  - rsp_valid_o = 0, rsp_rdata_o = 0, rsp_err_o = 0, rsp_cycles_o = 0.
  - cmd_ready_o = 1 once rst_i is low.
- Reset mid-transaction: the transaction is abandoned and no response is produced. The slave must be reset with it.
- FSM states: IDLE, WRITE, WAIT_B, READ, WAIT_R, RESP.
- IDLE:
  - cmd_ready_o = 1.
  - On handshake, register we/addr/wdata/strb and clear the counter.
  - Go to WRITE if we = 1, otherwise READ.
  - cmd_ready_o is 0 in every other state.
- WRITE:
  - aw_valid and w_valid both rise in the first cycle after acceptance.
  - aw.addr and w.data/strb come from the registered command; aw.prot = 0.
  - Each valid drops independently in the cycle after its own handshake. AW and W may complete in either order or in the same cycle.
  - Payloads are stable while valid is high.
  - When both AW and W are done, go to WAIT_B.
- WAIT_B:
  - b_ready = 1.
  - On b handshake: capture err = (b.resp != 2'b00), set rdata = 0, go to RESP.
- READ:
  - ar_valid = 1 with ar.addr registered; ar.prot = 0.
  - On ar handshake, go to WAIT_R.
- WAIT_R:
  - r_ready = 1.
  - On r handshake: capture r.data and err = (r.resp != 2'b00), go to RESP.
- RESP:
  - rsp_valid_o = 1 with rsp_rdata_o, rsp_err_o and rsp_cycles_o held stable.
  - On rsp_ready_i, go to IDLE.
  - The next command is accepted one cycle later, in IDLE.
- Latency counter:
  - Cleared on command accept.
  - Increments every cycle in WRITE/WAIT_B/READ/WAIT_R, including the B/R handshake cycle.
  - Frozen in RESP; saturates at 2^CntWidth-1.
  - Minimum value is 2 (1 cycle in the request state + 1 in the wait state when the slave responds immediately).
- No AXI channel is driven valid outside its own state. B/R handshakes cannot precede AW/W/AR completion.
- Stalls: any slave ready/valid stall simply holds the state. There is no timeout.

Test Plan:
- Write with zero-wait slave: cmd we=1, addr 0x0, wdata 0x0000_0001, strb 0xF -> aw/w valid together one cycle after accept; B OKAY; rsp_err_o=0, rsp_cycles_o=2, rsp_rdata_o=0.
- Read of a reset-valued register: addr 0x4, slave returns 0x8000_0000 OKAY -> rsp_rdata_o=0x8000_0000, rsp_err_o=0, rsp_cycles_o=2.
- Split AW/W acceptance: aw_ready delayed 3 cycles, w_ready immediate -> w_valid drops after 1 cycle; aw_valid holds 4 cycles; b_ready only after both; rsp_cycles_o=5.
- Error response: write to a read-only register at addr 0x8 with B SLVERR (2'b10) -> rsp_err_o=1; read with DECERR (2'b11) -> rsp_err_o=1.
- Response backpressure: rsp_ready_i low 5 cycles -> outputs stable; cmd_ready_o=0 throughout; the next command is accepted exactly 1 cycle after the rsp handshake.
- Async reset in WAIT_R (rst_i pulsed mid-cycle) -> r_ready/ar_valid/rsp_valid_o drop immediately; cmd_ready_o=1 after release; the next read completes normally.
